// File: rtl/instr_cache_l1.sv
// Direct-mapped L1 instruction cache with a line-refill FSM (IDLE/FILL/INSTALL).
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module instr_cache_l1 #(
    parameter int NUM_SETS    = 64,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] pc_f_i,
    input  logic                  ic_flush_i,
    output logic [31:0]           instr_f_o,
    output logic                  instr_hit_f_o,
    output logic                  ic_repl_permit_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rvalid_i,
`ifdef ICACHE_PERF_CNT_EN
    input  logic [31:0]           mem_rdata_i,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`else
    input  logic [31:0]           mem_rdata_i
`endif
);

    localparam int OB = $clog2(BLOCK_WORDS);
    localparam int IB = $clog2(NUM_SETS);
    localparam int TW = ADDR_WIDTH - OB - IB - 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FILL, INSTALL} state_t;

    state_t                  state_q, state_d;
    logic [NUM_SETS-1:0]     valid_q;
    logic [TW-1:0]           tag_arr [NUM_SETS];
    logic [31:0]             data_arr [NUM_SETS*BLOCK_WORDS];
    logic [31:0]             line_buf [BLOCK_WORDS];
    logic [OB-1:0]           beat_cnt_q;
    logic                    kill_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;

    logic [OB-1:0]           pc_off;
    logic [IB-1:0]           pc_idx, fill_idx;
    logic [TW-1:0]           pc_tag, fill_tag;
    logic                    is_idle, lookup_match, hit, start_fill, beat_en, last_beat, install_en;
    logic                    unused_pc_lsb;

    assign pc_off        = pc_f_i[OB+1:2];
    assign pc_idx        = pc_f_i[OB+IB+1:OB+2];
    assign pc_tag        = pc_f_i[ADDR_WIDTH-1:OB+IB+2];
    assign fill_idx      = mem_addr_q[OB+IB+1:OB+2];
    assign fill_tag      = mem_addr_q[ADDR_WIDTH-1:OB+IB+2];
    assign unused_pc_lsb = ^pc_f_i[1:0];

    assign is_idle      = (state_q == IDLE);
    assign lookup_match = valid_q[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    assign hit          = is_idle && lookup_match && !ic_flush_i;
    assign start_fill   = is_idle && !lookup_match && !ic_flush_i;
    assign beat_en      = (state_q == FILL) && mem_rvalid_i;
    assign last_beat    = beat_en && (beat_cnt_q == OB'(BLOCK_WORDS-1));
    // A flush landing in the install cycle itself must also suppress the install.
    assign install_en   = (state_q == INSTALL) && !kill_q && !ic_flush_i;

    assign instr_hit_f_o    = hit;
    assign instr_f_o        = hit ? data_arr[{pc_idx, pc_off}] : NOP;
    assign ic_repl_permit_o = is_idle;
    assign mem_req_o        = (state_q == FILL);
    assign mem_addr_o       = mem_addr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_fill) state_d = FILL;
            FILL:    if (last_beat)  state_d = INSTALL;
            INSTALL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            beat_cnt_q <= '0;
            kill_q     <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_fill) begin
                mem_addr_q <= {pc_f_i[ADDR_WIDTH-1:OB+2], {(OB+2){1'b0}}};
                beat_cnt_q <= '0;
                kill_q     <= 1'b0;
            end else begin
                if (beat_en)
                    beat_cnt_q <= beat_cnt_q + OB'(1);
                if (ic_flush_i && !is_idle)
                    kill_q <= 1'b1;
            end
            if (ic_flush_i)
                valid_q <= '0;
            else if (install_en)
                valid_q[fill_idx] <= 1'b1;
        end
    end

    // Storage arrays carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk_i) begin
        if (beat_en)
            line_buf[beat_cnt_q] <= mem_rdata_i;
        if (install_en) begin
            tag_arr[fill_idx] <= fill_tag;
            for (int w = 0; w < BLOCK_WORDS; w++)
                data_arr[{fill_idx, OB'(w)}] <= line_buf[w];
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (hit)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (start_fill)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_instr_cache_l1.sv
// Self-checking bench for instr_cache_l1: lookup vector table plus refill,
// flush, conflict, redirect and reset-mid-fill sequences with a memory responder.
module tb_instr_cache_l1;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_f = '0;
    logic        ic_flush = 1'b0;
    logic [31:0] instr_f;
    logic        instr_hit_f;
    logic        ic_repl_permit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    instr_cache_l1 dut (
        .clk_i            (clk),
        .reset_i          (reset_n),
        .pc_f_i           (pc_f),
        .ic_flush_i       (ic_flush),
        .instr_f_o        (instr_f),
        .instr_hit_f_o    (instr_hit_f),
        .ic_repl_permit_o (ic_repl_permit),
        .mem_req_o        (mem_req),
        .mem_addr_o       (mem_addr),
        .mem_rvalid_i     (mem_rvalid),
`ifdef ICACHE_PERF_CNT_EN
        .mem_rdata_i      (mem_rdata),
        .hit_cnt_o        (hit_cnt),
        .miss_cnt_o       (miss_cnt)
`else
        .mem_rdata_i      (mem_rdata)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        hit;
        logic [31:0] instr;
        logic        req;
        logic        permit;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] instr;
    } vec_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic h, input logic [31:0] ins,
                              input logic rq, input logic pm);
        exp_t e;
        e.name = nm; e.hit = h; e.instr = ins; e.req = rq; e.permit = pm;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".hit"},    {31'd0, instr_hit_f},    {31'd0, e.hit});
            chk({e.name, ".instr"},  instr_f,                 e.instr);
            chk({e.name, ".req"},    {31'd0, mem_req},        {31'd0, e.req});
            chk({e.name, ".permit"}, {31'd0, ic_repl_permit}, {31'd0, e.permit});
        end
    endtask

    task automatic lookup(input string nm, input logic [31:0] pc, input logic h, input logic [31:0] ins);
        pc_f = pc;
        ic_flush = 1'b0;
        mem_rvalid = 1'b0;
        expect_out(nm, h, h ? ins : NOP, 1'b0, 1'b1);
        sample();
        tick();
    endtask

    // Miss at pc, then serve a whole line d0..d0+3; returns right after the INSTALL cycle.
    task automatic refill(input string nm, input logic [31:0] pc, input logic [31:0] d0, input int gap,
                          input bit stray, input int flush_at, input logic [31:0] redir);
        pc_f = pc;
        ic_flush = 1'b0;
        mem_rvalid = stray;
        mem_rdata = 32'hDEAD_BEEF;
        expect_out({nm, ".miss"}, 1'b0, NOP, 1'b0, 1'b1);
        sample();
        tick();
        mem_rvalid = 1'b0;
        if (redir != 32'd0) pc_f = redir;
        chk({nm, ".addr"}, mem_addr, pc & ~32'h0000_000F);
        for (int b = 0; b < 4; b++) begin
            if (b == flush_at) begin
                ic_flush = 1'b1;
                mem_rvalid = 1'b0;
                expect_out({nm, ".flush"}, 1'b0, NOP, 1'b1, 1'b0);
                sample();
                tick();
                ic_flush = 1'b0;
            end
            for (int g = 0; g < gap; g++) begin
                mem_rvalid = 1'b0;
                expect_out({nm, ".gap"}, 1'b0, NOP, 1'b1, 1'b0);
                sample();
                tick();
            end
            mem_rvalid = 1'b1;
            mem_rdata = d0 + b;
            expect_out({nm, ".beat"}, 1'b0, NOP, 1'b1, 1'b0);
            sample();
            tick();
        end
        mem_rvalid = 1'b0;
        expect_out({nm, ".install"}, 1'b0, NOP, 1'b0, 1'b0);
        sample();
        tick();
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{32'h0000_0100, 1'b1, 32'hA0};
        tbl[1] = '{32'h0000_0108, 1'b1, 32'hA2};
        tbl[2] = '{32'h0000_010C, 1'b1, 32'hA3};
        tbl[3] = '{32'h0000_0103, 1'b1, 32'hA0};
        tbl[4] = '{32'h0000_0210, 1'b1, 32'hB0};
        tbl[5] = '{32'h0000_0214, 1'b1, 32'hB1};
        tbl[6] = '{32'h0000_021C, 1'b1, 32'hB3};
        tbl[7] = '{32'h0000_0104, 1'b1, 32'hA1};

        // reset state
        #3;
        pc_f = 32'h0000_0104;
        expect_out("reset", 1'b0, NOP, 1'b0, 1'b1);
        sample();
        chk("reset.addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // cold miss, back-to-back beats; hit six cycles after the miss
        refill("cold", 32'h0000_0104, 32'hA0, 0, 1'b0, -1, 32'h0);
        lookup("cold.hit6", 32'h0000_0104, 1'b1, 32'hA1);

        refill("gaps", 32'h0000_0210, 32'hB0, 3, 1'b0, -1, 32'h0);

        for (int i = 0; i < 8; i++)
            lookup($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].hit, tbl[i].instr);

        // conflict: same index, different tag
        refill("conflict", 32'h0000_0500, 32'hC0, 0, 1'b0, -1, 32'h0);
        lookup("conflict.new", 32'h0000_0504, 1'b1, 32'hC1);
        lookup("conflict.keep", 32'h0000_0214, 1'b1, 32'hB1);
        refill("conflict.old", 32'h0000_0100, 32'hA0, 0, 1'b0, -1, 32'h0);
        lookup("conflict.back", 32'h0000_0100, 1'b1, 32'hA0);

        // flush after beat 1: fill completes but does not install
        refill("kill", 32'h0000_0300, 32'hD0, 0, 1'b0, 2, 32'h0);
        refill("kill.again", 32'h0000_0300, 32'hE0, 0, 1'b0, -1, 32'h0);
        lookup("kill.hit", 32'h0000_0300, 1'b1, 32'hE0);
        refill("kill.other", 32'h0000_0100, 32'hA0, 0, 1'b0, -1, 32'h0);
        lookup("kill.other_hit", 32'h0000_0100, 1'b1, 32'hA0);

        // flush in IDLE together with a miss: flush only, then everything misses
        pc_f = 32'h0000_0600;
        ic_flush = 1'b1;
        expect_out("idle_flush", 1'b0, NOP, 1'b0, 1'b1);
        sample();
        tick();
        ic_flush = 1'b0;
        refill("postflush.600", 32'h0000_0600, 32'hF0, 0, 1'b0, -1, 32'h0);
        refill("postflush.100", 32'h0000_0100, 32'hA0, 0, 1'b0, -1, 32'h0);
        refill("postflush.300", 32'h0000_0300, 32'hE0, 0, 1'b0, -1, 32'h0);

        // redirect during refill: the latched line still installs
        refill("redir", 32'h0000_0700, 32'h70, 1, 1'b0, -1, 32'h0000_0600);
        lookup("redir.cur", 32'h0000_0600, 1'b1, 32'hF0);
        lookup("redir.line", 32'h0000_0708, 1'b1, 32'h72);

        // async reset after beat 2
        pc_f = 32'h0000_0400;
        expect_out("rst.miss", 1'b0, NOP, 1'b0, 1'b1);
        sample();
        tick();
        for (int b = 0; b < 3; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata = 32'hBAD0 + b;
            tick();
        end
        mem_rvalid = 1'b0;
        #2;
        reset_n = 1'b0;
        expect_out("rst.mid", 1'b0, NOP, 1'b0, 1'b1);
        sample();
        chk("rst.addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        refill("rst.refill", 32'h0000_0400, 32'h60, 0, 1'b1, -1, 32'h0);
        lookup("rst.w0", 32'h0000_0400, 1'b1, 32'h60);
        lookup("rst.w1", 32'h0000_0404, 1'b1, 32'h61);
        lookup("rst.w2", 32'h0000_0408, 1'b1, 32'h62);
        lookup("rst.w3", 32'h0000_040C, 1'b1, 32'h63);
        lookup("rst.w0b", 32'h0000_0400, 1'b1, 32'h60);
`ifdef ICACHE_PERF_CNT_EN
        chk("perf.miss", miss_cnt, 32'd1);
        chk("perf.hit", hit_cnt, 32'd5);
`endif
        refill("rst.stale", 32'h0000_0100, 32'hA8, 0, 1'b0, -1, 32'h0);
        lookup("rst.stale_hit", 32'h0000_0104, 1'b1, 32'hA9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
